// File: rtl/vga_draw_arbiter_pkg.sv
// Shared definitions for the VGA draw arbiter slice.
//
// Contents:
//   SCR_W, SCR_H     default visible screen size in pixels
//   state_t          arbiter FSM states (S_IDLE, S_DRAW, S_DONE)
//   BLACK/RED/WHITE  3-bit colour constants used by the drawing clients
package vga_draw_arbiter_pkg;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/vga_draw_arbiter_rr.sv
// Combinational round-robin arbiter.
//
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  IW    index of the most recently served client
//   grant  out NREQ  one-hot grant (all zero when no request)
//   idx    out IW    index of the granted client (0 when no request)
//
// The search starts at ptr+1 and wraps, so the last winner has the lowest
// priority on the next round.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    always_comb begin
        logic found;
        int   cand;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(ptr) + i) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Shares the vga_adapter pixel-write port among NREQ rectangle-fill clients.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   req_valid/x/y/w/h/colour per-client rectangle command (8-bit fields
//                            packed at [8i+7:8i], colour at [CW*i+:CW])
//   req_ready                one-cycle accept pulse to the granted client
//   req_done                 one-cycle completion pulse to the owner
//   pix_x/pix_y/pix_colour   registered pixel to vga_adapter
//   pix_plot                 write strobe, low for clipped pixels
//   busy                     high whenever the FSM is not idle
//
// A granted rectangle is swept row-major at one pixel per clock. Off-screen
// pixels still take a cycle but are not plotted.
module vga_draw_arbiter
    import vga_draw_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int SCR_W = vga_draw_arbiter_pkg::SCR_W,
    parameter int SCR_H = vga_draw_arbiter_pkg::SCR_H,
    parameter int CW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*8-1:0]    req_x,
    input  logic [NREQ*8-1:0]    req_y,
    input  logic [NREQ*8-1:0]    req_w,
    input  logic [NREQ*8-1:0]    req_h,
    input  logic [NREQ*CW-1:0]   req_colour,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      req_done,
    output logic [7:0]           pix_x,
    output logic [7:0]           pix_y,
    output logic [CW-1:0]        pix_colour,
    output logic                 pix_plot,
    output logic                 busy
);

    localparam int IW = $clog2(NREQ);

    state_t          state, state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic [NREQ-1:0] owner_oh;
    logic [7:0]      x0, y0, w, h, cx, cy;
    logic [CW-1:0]   colour;
    logic            zero_cmd;
    logic [7:0]      sel_w, sel_h;
    logic [8:0]      x_sum, y_sum;
    logic            last_pixel;
    logic            any_req;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant_oh),
        .idx   (grant_idx)
    );

    assign any_req    = |req_valid;
    assign sel_w      = req_w[8*grant_idx +: 8];
    assign sel_h      = req_h[8*grant_idx +: 8];
    assign x_sum      = {1'b0, x0} + {1'b0, cx};
    assign y_sum      = {1'b0, y0} + {1'b0, cy};
    assign last_pixel = (cx == w - 8'd1) && (cy == h - 8'd1);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-width or zero-height command skips the sweep entirely.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_next = (sel_w != 8'd0 && sel_h != 8'd0) ? S_DRAW : S_DONE;
                end
            end
            S_DRAW: begin
                if (last_pixel) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Pixel outputs are registered, so the done pulse for a drawn rectangle
    // is launched together with the last pixel. A zero-size command launches
    // its done pulse from DONE instead, one cycle after its ready pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr     <= IW'(NREQ - 1);
            owner_oh   <= '0;
            x0         <= '0;
            y0         <= '0;
            w          <= '0;
            h          <= '0;
            cx         <= '0;
            cy         <= '0;
            colour     <= '0;
            zero_cmd   <= 1'b0;
            req_ready  <= '0;
            req_done   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= '0;
            pix_plot   <= 1'b0;
        end else begin
            req_ready  <= '0;
            req_done   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_colour <= CW'(BLACK);
            pix_plot   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        rr_ptr    <= grant_idx;
                        owner_oh  <= grant_oh;
                        req_ready <= grant_oh;
                        x0        <= req_x[8*grant_idx +: 8];
                        y0        <= req_y[8*grant_idx +: 8];
                        w         <= sel_w;
                        h         <= sel_h;
                        colour    <= req_colour[CW*grant_idx +: CW];
                        zero_cmd  <= (sel_w == 8'd0) || (sel_h == 8'd0);
                        cx        <= '0;
                        cy        <= '0;
                    end
                end
                S_DRAW: begin
                    pix_x      <= x_sum[7:0];
                    pix_y      <= y_sum[7:0];
                    pix_colour <= colour;
                    pix_plot   <= (x_sum < 9'(SCR_W)) && (y_sum < 9'(SCR_H));
                    if (cx == w - 8'd1) begin
                        cx <= '0;
                        cy <= cy + 8'd1;
                    end else begin
                        cx <= cx + 8'd1;
                    end
                    if (last_pixel) begin
                        req_done <= owner_oh;
                    end
                end
                S_DONE: begin
                    if (zero_cmd) begin
                        req_done <= owner_oh;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter. A transaction-level model keeps
// per-client command tables, decides grants from the round-robin rule and
// fills per-cycle expectation arrays for ready, done, busy and pixels.
module tb_vga_draw_arbiter;
    import vga_draw_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int CW   = 3;
    localparam int SW   = 160;
    localparam int SH   = 120;
    localparam int MAXC = 20000;
    localparam int TABN = 32;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*8-1:0]   req_x = '0;
    logic [NREQ*8-1:0]   req_y = '0;
    logic [NREQ*8-1:0]   req_w = '0;
    logic [NREQ*8-1:0]   req_h = '0;
    logic [NREQ*CW-1:0]  req_colour = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_done;
    logic [7:0]          pix_x;
    logic [7:0]          pix_y;
    logic [CW-1:0]       pix_colour;
    logic                pix_plot;
    logic                busy;

    vga_draw_arbiter #(.NREQ(NREQ), .SCR_W(SW), .SCR_H(SH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .req_ready  (req_ready),
        .req_done   (req_done),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .pix_plot   (pix_plot),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int col;
        int start;
    } cmd_t;

    cmd_t tab[NREQ][TABN];
    int   tab_n[NREQ];
    int   tab_head[NREQ];
    int   tab_avail[NREQ];

    int exp_ready[MAXC];
    int exp_done[MAXC];
    int exp_busy[MAXC];
    int exp_plot[MAXC];
    int exp_x[MAXC];
    int exp_y[MAXC];
    int exp_col[MAXC];

    int order[$];
    int obs_plots;
    int m_ptr;
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic clear_table();
        for (int i = 0; i < NREQ; i++) begin
            tab_n[i]     = 0;
            tab_head[i]  = 0;
            tab_avail[i] = 0;
        end
    endtask

    task automatic add_cmd(input int cl, input int x, input int y, input int w,
                           input int h, input int col, input int start);
        cmd_t c;
        c.x = x; c.y = y; c.w = w; c.h = h; c.col = col; c.start = start;
        tab[cl][tab_n[cl]] = c;
        tab_n[cl]++;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ptr = NREQ - 1;
    endtask

    // Runs the command tables to completion, checking every output each cycle.
    task automatic run_window(input string name);
        int              c;
        int              idle_from;
        bit              finished;
        bit              all_used;
        logic [NREQ-1:0] vec;
        int              g;
        int              n;
        int              px;
        int              py;
        int              hd;
        cmd_t            cm;
        for (int i = 0; i < MAXC; i++) begin
            exp_ready[i] = 0; exp_done[i] = 0; exp_busy[i] = 0;
            exp_plot[i] = 0; exp_x[i] = 0; exp_y[i] = 0; exp_col[i] = 0;
        end
        order.delete();
        obs_plots = 0;
        idle_from = 0;
        c = 0;
        finished = 1'b0;
        while (!finished) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (req_ready !== NREQ'(exp_ready[c])) begin
                n_fail++;
                $display("[TB] FAIL %s ready c=%0d got %b expected %b", name, c, req_ready, NREQ'(exp_ready[c]));
            end
            n_cmp++;
            if (req_done !== NREQ'(exp_done[c])) begin
                n_fail++;
                $display("[TB] FAIL %s done c=%0d got %b expected %b", name, c, req_done, NREQ'(exp_done[c]));
            end
            n_cmp++;
            if (busy !== 1'(exp_busy[c])) begin
                n_fail++;
                $display("[TB] FAIL %s busy c=%0d got %b expected %0d", name, c, busy, exp_busy[c]);
            end
            n_cmp++;
            if (pix_plot !== 1'(exp_plot[c]) || pix_x !== 8'(exp_x[c]) ||
                pix_y !== 8'(exp_y[c]) || pix_colour !== CW'(exp_col[c])) begin
                n_fail++;
                $display("[TB] FAIL %s pixel c=%0d got plot=%b x=%0d y=%0d col=%0d expected plot=%0d x=%0d y=%0d col=%0d",
                         name, c, pix_plot, pix_x, pix_y, pix_colour, exp_plot[c], exp_x[c], exp_y[c], exp_col[c]);
            end
            if (pix_plot === 1'b1) obs_plots++;

            vec = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (tab_head[i] < tab_n[i] && tab[i][tab_head[i]].start <= c && tab_avail[i] <= c)
                    vec[i] = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (vec[i]) begin
                    cm = tab[i][tab_head[i]];
                    req_x[8*i +: 8]       = 8'(cm.x);
                    req_y[8*i +: 8]       = 8'(cm.y);
                    req_w[8*i +: 8]       = 8'(cm.w);
                    req_h[8*i +: 8]       = 8'(cm.h);
                    req_colour[CW*i +: CW] = CW'(cm.col);
                end else begin
                    req_x[8*i +: 8]       = 8'($urandom);
                    req_y[8*i +: 8]       = 8'($urandom);
                    req_w[8*i +: 8]       = 8'($urandom);
                    req_h[8*i +: 8]       = 8'($urandom);
                    req_colour[CW*i +: CW] = CW'($urandom);
                end
            end
            req_valid = vec;

            g = -1;
            if (c >= idle_from && vec != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (g < 0 && vec[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
                end
                m_ptr = g;
                order.push_back(g);
                hd = tab_head[g];
                cm = tab[g][hd];
                n = cm.w * cm.h;
                if (c + n + 3 < MAXC) begin
                    exp_ready[c+1] = 1 << g;
                    if (n == 0) begin
                        exp_busy[c+1] = 1;
                        exp_done[c+2] = 1 << g;
                        idle_from = c + 2;
                    end else begin
                        for (int k = 0; k < n; k++) begin
                            px = cm.x + (k % cm.w);
                            py = cm.y + (k / cm.w);
                            exp_x[c+2+k]    = px % 256;
                            exp_y[c+2+k]    = py % 256;
                            exp_col[c+2+k]  = cm.col;
                            exp_plot[c+2+k] = (px < SW && py < SH) ? 1 : 0;
                        end
                        for (int b = c + 1; b <= c + 1 + n; b++) exp_busy[b] = 1;
                        exp_done[c+1+n] = 1 << g;
                        idle_from = c + n + 2;
                    end
                end
                tab_head[g] = hd + 1;
                tab_avail[g] = c + 1;
            end

            all_used = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (tab_head[i] < tab_n[i]) all_used = 1'b0;
            end
            if (all_used && c >= idle_from + 2) finished = 1'b1;
            if (!finished && c >= MAXC - 400) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL %s timeout c=%0d", name, c);
                finished = 1'b1;
            end
            c++;
        end
        req_valid = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = NREQ'($urandom);
            req_w = {NREQ{8'd3}};
            req_h = {NREQ{8'd3}};
            @(posedge clk);
            #1;
            n_cmp++;
            if (req_ready !== '0 || req_done !== '0 || busy !== 1'b0 || pix_plot !== 1'b0 ||
                pix_x !== 8'd0 || pix_y !== 8'd0 || pix_colour !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_state got ready=%b done=%b busy=%b plot=%b x=%0d y=%0d col=%0d expected all 0",
                         req_ready, req_done, busy, pix_plot, pix_x, pix_y, pix_colour);
            end
        end
        req_valid = '0;
        rst = 1'b1;
        m_ptr = NREQ - 1;
    endtask

    task automatic test_single_column();
        clear_table();
        add_cmd(1, 10, 52, 1, 16, int'(WHITE), 0);
        run_window("single_column");
        n_cmp++;
        if (order.size() != 1 || order[0] != 1) begin
            n_fail++;
            $display("[TB] FAIL single_column_winner got %0d grants expected client 1", order.size());
        end
        n_cmp++;
        if (obs_plots != 16) begin
            n_fail++;
            $display("[TB] FAIL single_column_plots got %0d expected 16", obs_plots);
        end
    endtask

    task automatic test_contention();
        int want[4];
        want[0] = 0; want[1] = 2; want[2] = 3; want[3] = 0;
        do_reset();
        clear_table();
        add_cmd(0, 20, 20, 2, 2, 1, 0);
        add_cmd(2, 30, 30, 2, 2, 2, 0);
        add_cmd(3, 40, 40, 2, 2, 3, 1);
        add_cmd(0, 50, 50, 2, 2, 5, 1);
        run_window("contention");
        n_cmp++;
        if (order.size() != 4) begin
            n_fail++;
            $display("[TB] FAIL contention_count got %0d expected 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (order[i] != want[i]) begin
                    n_fail++;
                    $display("[TB] FAIL contention_order slot %0d got %0d expected %0d", i, order[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_clip();
        clear_table();
        add_cmd(0, 158, 118, 4, 4, int'(RED), 0);
        run_window("clip");
        n_cmp++;
        if (obs_plots != 4) begin
            n_fail++;
            $display("[TB] FAIL clip_plots got %0d expected 4", obs_plots);
        end
    endtask

    task automatic test_zero_size();
        clear_table();
        add_cmd(3, 5, 5, 0, 5, int'(WHITE), 0);
        add_cmd(2, 7, 7, 3, 0, int'(WHITE), 0);
        run_window("zero_size");
        n_cmp++;
        if (obs_plots != 0) begin
            n_fail++;
            $display("[TB] FAIL zero_size_plots got %0d expected 0", obs_plots);
        end
    endtask

    task automatic test_reset_mid_sweep();
        req_valid = 4'b0001;
        req_x[7:0] = 8'd0; req_y[7:0] = 8'd0;
        req_w[7:0] = 8'd160; req_h[7:0] = 8'd120;
        req_colour[CW-1:0] = WHITE;
        @(posedge clk);
        #1;
        req_valid = '0;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL mid_sweep_ready got %b expected 0001", req_ready);
        end
        m_ptr = 0;
        repeat (50) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b1 || pix_plot !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_sweep_active got busy=%b plot=%b expected 1 1", busy, pix_plot);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ptr = NREQ - 1;
        n_cmp++;
        if (pix_plot !== 1'b0 || busy !== 1'b0 || req_done !== '0 || pix_x !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_sweep_abort got plot=%b busy=%b done=%b x=%0d expected 0 0 0000 0",
                     pix_plot, busy, req_done, pix_x);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (req_done !== '0 || busy !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL mid_sweep_quiet got done=%b busy=%b expected 0000 0", req_done, busy);
            end
        end
        clear_table();
        add_cmd(0, 1, 1, 1, 1, 2, 0);
        add_cmd(1, 2, 2, 1, 1, 3, 0);
        run_window("after_reset");
        n_cmp++;
        if (order.size() < 1 || order[0] != 0) begin
            n_fail++;
            $display("[TB] FAIL after_reset_winner got %0d expected 0", (order.size() > 0) ? order[0] : -1);
        end
    endtask

    task automatic test_full_clear();
        clear_table();
        add_cmd(0, 0, 0, 160, 120, int'(BLACK), 0);
        run_window("full_clear");
        n_cmp++;
        if (obs_plots != 19200) begin
            n_fail++;
            $display("[TB] FAIL full_clear_plots got %0d expected 19200", obs_plots);
        end
    endtask

    task automatic test_random();
        int nc;
        for (int r = 0; r < 3; r++) begin
            clear_table();
            for (int i = 0; i < NREQ; i++) begin
                nc = $urandom_range(0, 4);
                for (int k = 0; k < nc; k++) begin
                    add_cmd(i,
                            ($urandom_range(0, 3) == 0) ? $urandom_range(150, 255) : $urandom_range(0, 159),
                            ($urandom_range(0, 3) == 0) ? $urandom_range(110, 255) : $urandom_range(0, 119),
                            $urandom_range(0, 6), $urandom_range(0, 6),
                            $urandom_range(0, 7), $urandom_range(0, 40));
                end
            end
            run_window("random");
        end
    endtask

    initial begin
        test_reset();
        test_single_column();
        test_contention();
        test_clip();
        test_zero_size();
        test_reset_mid_sweep();
        test_full_clear();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
